// File: rtl/cycle_pkg.sv
// Shared encodings for the two-player cycle mover: directions, game states and the
// toroidal 64x64 grid geometry.
package cycle_pkg;

   localparam int unsigned GridSize = 64;
   localparam int unsigned CoordW   = 6;

   typedef enum logic [1:0] {
      DirUp    = 2'd0,
      DirRight = 2'd1,
      DirDown  = 2'd2,
      DirLeft  = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StOver = 2'd2
   } state_e;

   typedef struct packed {
      logic [CoordW-1:0] x;
      logic [CoordW-1:0] y;
   } cell_t;

   // Opposite directions differ only in bit 1 (0<->2, 1<->3).
   function automatic logic is_reverse(dir_e a, dir_e b);
      return (a ^ b) == 2'd2;
   endfunction

   // Wrap-around falls out of the CoordW-bit arithmetic.
   function automatic cell_t next_cell(cell_t c, dir_e d);
      cell_t n;
      n = c;
      unique case (d)
         DirUp:    n.y = c.y - CoordW'(1);
         DirRight: n.x = c.x + CoordW'(1);
         DirDown:  n.y = c.y + CoordW'(1);
         DirLeft:  n.x = c.x - CoordW'(1);
         default:  n = c;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step timer: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
module tick_divider #(
   parameter int unsigned TICK_DIV = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam int unsigned CntW = $clog2(TICK_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/cycle_mover.sv
// Two-player light-cycle movement engine: alternates player steps on a divided tick and
// strobes each new cell to the grid for one cycle.
module cycle_mover
   import cycle_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1000000,
   parameter int unsigned P1_X0    = 8,
   parameter int unsigned P1_Y0    = 32,
   parameter int unsigned P2_X0    = 55,
   parameter int unsigned P2_Y0    = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [1:0]  dir_p1_i,
   input  logic        dir_p1_valid_i,
   input  logic [1:0]  dir_p2_i,
   input  logic        dir_p2_valid_i,
   input  logic [4:0]  exc_in_i,
   output logic [31:0] play_x_o,
   output logic [31:0] play_y_o,
   output logic        play_num_o,
   output logic        super_enable_o,
   output logic [1:0]  game_state_o,
   output logic [2:0]  result_o
);

   localparam cell_t P1Start = cell_t'({CoordW'(P1_X0), CoordW'(P1_Y0)});
   localparam cell_t P2Start = cell_t'({CoordW'(P2_X0), CoordW'(P2_Y0)});

   state_e     state_q, state_d;
   cell_t      p1_q, p1_d, p2_q, p2_d, play_q, play_d;
   dir_e       dir1_q, dir1_d, dir2_q, dir2_d;
   dir_e       pend1_q, pend1_d, pend2_q, pend2_d;
   logic       turn_q, turn_d;
   logic       num_q, num_d;
   logic       strobe_q, strobe_d;
   logic [2:0] result_q, result_d;

   logic  run, enter_idle, tc, step;
   cell_t cur_cell, nxt_cell;
   dir_e  cur_dir;
   logic  unused_exc;

   assign unused_exc = exc_in_i[3];
   assign run        = (state_q == StRun);
   assign enter_idle = (state_q == StOver) && start_i;
   // Game end wins over a coincident step.
   assign step       = tc && !exc_in_i[0];

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (run),
      .clr_i  (enter_idle),
      .tc_o   (tc)
   );

   // Single next-cell unit shared by both players via the turn mux.
   assign cur_cell = turn_q ? p2_q : p1_q;
   assign cur_dir  = turn_q ? pend2_q : pend1_q;
   assign nxt_cell = next_cell(cur_cell, cur_dir);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i)     state_d = StRun;
         StRun:   if (exc_in_i[0]) state_d = StOver;
         StOver:  if (start_i)     state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      p1_d     = p1_q;
      p2_d     = p2_q;
      dir1_d   = dir1_q;
      dir2_d   = dir2_q;
      pend1_d  = pend1_q;
      pend2_d  = pend2_q;
      turn_d   = turn_q;
      play_d   = play_q;
      num_d    = num_q;
      strobe_d = 1'b0;
      result_d = result_q;
      if (enter_idle) begin
         p1_d     = P1Start;
         p2_d     = P2Start;
         dir1_d   = DirRight;
         dir2_d   = DirLeft;
         pend1_d  = DirRight;
         pend2_d  = DirLeft;
         turn_d   = 1'b0;
         result_d = '0;
      end else if (run) begin
         if (step) begin
            if (!turn_q) begin
               p1_d   = nxt_cell;
               dir1_d = pend1_q;
            end else begin
               p2_d   = nxt_cell;
               dir2_d = pend2_q;
            end
            turn_d   = !turn_q;
            play_d   = nxt_cell;
            num_d    = turn_q;
            strobe_d = 1'b1;
         end
         // Requests are judged against the direction committed after this cycle.
         if (dir_p1_valid_i && !is_reverse(dir_e'(dir_p1_i), dir1_d)) begin
            pend1_d = dir_e'(dir_p1_i);
         end
         if (dir_p2_valid_i && !is_reverse(dir_e'(dir_p2_i), dir2_d)) begin
            pend2_d = dir_e'(dir_p2_i);
         end
         if (exc_in_i[0]) begin
            result_d = {exc_in_i[4], exc_in_i[2], exc_in_i[1]};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         p1_q     <= P1Start;
         p2_q     <= P2Start;
         dir1_q   <= DirRight;
         dir2_q   <= DirLeft;
         pend1_q  <= DirRight;
         pend2_q  <= DirLeft;
         turn_q   <= 1'b0;
         play_q   <= P1Start;
         num_q    <= 1'b0;
         strobe_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         dir1_q   <= dir1_d;
         dir2_q   <= dir2_d;
         pend1_q  <= pend1_d;
         pend2_q  <= pend2_d;
         turn_q   <= turn_d;
         play_q   <= play_d;
         num_q    <= num_d;
         strobe_q <= strobe_d;
         result_q <= result_d;
      end
   end

   assign play_x_o       = 32'(play_q.x);
   assign play_y_o       = 32'(play_q.y);
   assign play_num_o     = num_q;
   assign super_enable_o = strobe_q;
   assign game_state_o   = state_q;
   assign result_o       = result_q;

endmodule

// File: doc/cycle_mover.md
CYCLE_MOVER -- requirements
Module: cycle_mover

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clock cycles per movement step (min 2).
REQ-002 Parameter P1_X0/P1_Y0, default 8/32, player-1 start cell.
REQ-003 Parameter P2_X0/P2_Y0, default 55/32, player-2 start cell.
REQ-004 clock  in  1  single system clock, all state rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse: begin game (IDLE) or return to IDLE (OVER).
REQ-007 dir_p1 / dir_p2  in  2 each  requested direction: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1).
REQ-008 dir_p1_valid / dir_p2_valid  in  1 each  qualifies the matching dir input for one cycle.
REQ-009 exc_in  in  5  grid exception word: [0] game end, [1] player-1 win flag, [2] any win, [4] crash.
REQ-010 play_x / play_y  out  32 each  cell of the moving player, zero-extended from 6 bits.
REQ-011 play_num  out  1  0 = player 1, 1 = player 2.
REQ-012 super_enable  out  1  one-cycle commit strobe for the grid.
REQ-013 game_state  out  2  0 IDLE, 1 RUN, 2 OVER.
REQ-014 result  out  3  latched {exc_in[4], exc_in[2], exc_in[1]} at game end.

Function
REQ-015 FSM states IDLE, RUN, OVER; IDLE->RUN on start; RUN->OVER on exc_in[0]; OVER->IDLE on start; start in RUN is ignored.
REQ-016 Entering IDLE resets both positions to their start cells, dir1 to right (1), dir2 to left (3), turn to player 1, and the tick counter to 0.
REQ-017 In RUN the tick counter counts 0..TICK_DIV-1 and wraps; the terminal count is the step cycle.
REQ-018 On a step cycle, the player selected by turn advances one cell in its committed direction, and turn toggles.
REQ-019 The cycle after a step cycle drives play_x/play_y with the new cell, play_num with that player, and super_enable=1 for exactly one cycle.
REQ-020 Coordinates are 6-bit, modulo 64: x=63 moving right gives 0, and y=0 moving up gives 63.
REQ-021 A valid direction is captured into that player's pending register; the last valid non-reverse request since the previous step wins.
REQ-022 A request opposite to the committed direction (0<->2, 1<->3) is discarded.
REQ-023 The pending direction becomes committed at that player's next step and is used for that step.
REQ-024 A valid request on the same cycle as a step applies to the player's following step.
REQ-025 When exc_in[0] and a step cycle coincide, the step is suppressed, no super_enable is issued, and the state goes to OVER.
REQ-026 result is captured on the RUN->OVER transition and held until IDLE is entered, which clears it to 0.
REQ-027 In IDLE and OVER, super_enable=0, the tick counter is frozen, and play_x/play_y/play_num hold their last values.
REQ-028 Direction inputs are ignored outside RUN.

Reset
REQ-029 Asserting reset asynchronously sets state IDLE, play_x=P1_X0, play_y=P1_Y0, play_num=0, super_enable=0, result=0, counter=0, dir1=1, dir2=3, turn=0.
REQ-030 Reset asserted mid-step aborts any pending strobe; no super_enable appears in the cycle after deassertion.

Structure
REQ-031 Shared package cycle_pkg holds the direction encoding, FSM state encoding, grid size 64 and coordinate width 6.
REQ-032 One sub-module, tick_divider (counter, enable, terminal-count pulse output), is instantiated once.
REQ-033 The move logic (next-cell compute and wrap) is combinational and shared between both players through the turn mux.

Verification (TICK_DIV=4)
REQ-034 Reset, start, no dir input: the first strobe is at cycle 5 after start with (9,32, play_num 0); the second at cycle 9 with (54,32, play_num 1).
REQ-035 P1 at x=63 moving right: after the step, strobe with play_x=0; P2 at y=0 moving up: strobe with play_y=63.
REQ-036 dir_p1=3 while P1 moves right: ignored and the next P1 move is x+1; dir_p1=0 then dir_p1=2 before the step: 2 is discarded as the reverse of 1? No: 2 is not a reverse of right, so the last request (2, down) wins and gives y+1.
REQ-037 exc_in=5'b10001 on a step cycle: no strobe, game_state=2, result=3'b100; start then gives game_state=0, result=0, start cells restored.
REQ-038 Reset asserted on the step cycle and released 2 cycles later: all outputs match REQ-029 and super_enable stays 0.
